// File: rtl/ecc_collect_pkg.sv
// Shared types and defaults for the ECC result collector.
// Holds log FSM states, error classes and the word classifier.
package ecc_collect_pkg;

  localparam int DATA_W    = 16;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_TAG_W = 8;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    LOG_IDLE,
    LOG_HELD,
    LOG_OVERRUN
  } log_state_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_SEC,
    ERR_DED
  } err_class_t;

  // DED dominates: a word flagged both ways is uncorrectable.
  function automatic err_class_t classify(
    input logic sec,
    input logic ded
  );
    if (ded)      return ERR_DED;
    else if (sec) return ERR_SEC;
    else          return ERR_NONE;
  endfunction

endpackage

// File: rtl/ecc_sync_fifo.sv
// Synchronous FIFO with valid/ready on both sides, no bypass.
// Ports: i_clk, i_rst, i_valid/o_ready/i_data in, o_valid/i_ready/o_data out.
module ecc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign o_ready = !w_full;
  assign o_valid = !w_empty;
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_valid & !w_full;
  assign w_pop   = i_ready & !w_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ecc_result_collector.sv
// Buffers corrected ECC words, counts SEC/DED, logs the first error.
// Ports: in_* upstream, out_* consumer, *_count, log_*, irq_en/irq.
module ecc_result_collector
  import ecc_collect_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int TAG_W = DEF_TAG_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              in_sec,
  input  logic              in_ded,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_poison,
  output logic [CNT_W-1:0]  sec_count,
  output logic [CNT_W-1:0]  ded_count,
  output logic              log_valid,
  output logic              log_ded,
  output logic [TAG_W-1:0]  log_tag,
  output logic              log_overrun,
  input  logic              log_clr,
  input  logic              irq_en,
  output logic              irq
);

  localparam int FW = DATA_W + TAG_W + 1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [FW-1:0] w_wr_word;
  logic [FW-1:0] w_rd_word;
  logic          w_push;
  err_class_t    w_class;
  logic          w_err;
  logic          w_is_ded;

  log_state_t       r_state;
  logic [TAG_W-1:0] r_log_tag;
  logic             r_log_ded;
  logic [CNT_W-1:0] r_sec_cnt;
  logic [CNT_W-1:0] r_ded_cnt;
  logic             r_irq;

  assign w_wr_word = {in_data, in_tag, in_ded};
  assign w_push    = in_valid & in_ready;
  assign w_class   = classify(in_sec, in_ded);
  assign w_is_ded  = (w_class == ERR_DED);
  assign w_err     = w_push & (w_class != ERR_NONE);

  ecc_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_data  (w_wr_word),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (w_rd_word)
  );

  assign out_data   = w_rd_word[FW-1 -: DATA_W];
  assign out_tag    = w_rd_word[TAG_W:1];
  assign out_poison = w_rd_word[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sec_cnt <= '0;
      r_ded_cnt <= '0;
    end else if (w_push) begin
      if (w_class == ERR_DED && r_ded_cnt != '1)
        r_ded_cnt <= r_ded_cnt + ONE;
      if (w_class == ERR_SEC && r_sec_cnt != '1)
        r_sec_cnt <= r_sec_cnt + ONE;
    end
  end

  // A clear coinciding with an error restarts the log on that error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= LOG_IDLE;
      r_log_tag <= '0;
      r_log_ded <= 1'b0;
    end else if (log_clr) begin
      r_state <= w_err ? LOG_HELD : LOG_IDLE;
      if (w_err) begin
        r_log_tag <= in_tag;
        r_log_ded <= w_is_ded;
      end
    end else begin
      case (r_state)
        LOG_IDLE: begin
          if (w_err) begin
            r_state   <= LOG_HELD;
            r_log_tag <= in_tag;
            r_log_ded <= w_is_ded;
          end
        end
        LOG_HELD: begin
          if (w_err) r_state <= LOG_OVERRUN;
        end
        LOG_OVERRUN: r_state <= LOG_OVERRUN;
        default:     r_state <= LOG_IDLE;
      endcase
    end
  end

  // Built from the registered log, so it trails log_valid by a cycle.
  always_ff @(posedge clk) begin
    if (rst) r_irq <= 1'b0;
    else     r_irq <= log_valid & r_log_ded & irq_en;
  end

  assign log_valid   = (r_state != LOG_IDLE);
  assign log_overrun = (r_state == LOG_OVERRUN);
  assign log_tag     = r_log_tag;
  assign log_ded     = r_log_ded;
  assign sec_count   = r_sec_cnt;
  assign ded_count   = r_ded_cnt;
  assign irq         = r_irq;

endmodule

// File: tb/tb_ecc_result_collector.sv
// Randomised + directed bench for ecc_result_collector.
// Queue-based reference model compared every negedge.
module tb_ecc_result_collector;

  localparam int DEPTH = 4;
  localparam int MAX1  = 65535;
  localparam int MAX2  = 3;

  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0;
  logic [15:0] in_data = 0;
  logic [7:0]  in_tag = 0;
  logic        in_sec = 0;
  logic        in_ded = 0;
  logic        out_ready = 0;
  logic        log_clr = 0;
  logic        irq_en = 0;

  logic        in_ready, out_valid, out_poison;
  logic [15:0] out_data;
  logic [7:0]  out_tag, log_tag;
  logic [15:0] sec_count, ded_count;
  logic        log_valid, log_ded, log_overrun, irq;

  logic        d2_in_ready, d2_out_valid, d2_out_poison;
  logic [15:0] d2_out_data;
  logic [7:0]  d2_out_tag, d2_log_tag;
  logic [1:0]  d2_sec, d2_ded;
  logic        d2_log_valid, d2_log_ded, d2_log_ovr, d2_irq;

  always #5 clk = ~clk;

  ecc_result_collector #(.DEPTH(4), .TAG_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_tag(in_tag),
    .in_sec(in_sec), .in_ded(in_ded),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag),
    .out_poison(out_poison),
    .sec_count(sec_count), .ded_count(ded_count),
    .log_valid(log_valid), .log_ded(log_ded),
    .log_tag(log_tag), .log_overrun(log_overrun),
    .log_clr(log_clr), .irq_en(irq_en), .irq(irq)
  );

  ecc_result_collector #(.DEPTH(4), .TAG_W(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(d2_in_ready),
    .in_data(in_data), .in_tag(in_tag),
    .in_sec(in_sec), .in_ded(in_ded),
    .out_valid(d2_out_valid), .out_ready(out_ready),
    .out_data(d2_out_data), .out_tag(d2_out_tag),
    .out_poison(d2_out_poison),
    .sec_count(d2_sec), .ded_count(d2_ded),
    .log_valid(d2_log_valid), .log_ded(d2_log_ded),
    .log_tag(d2_log_tag), .log_overrun(d2_log_ovr),
    .log_clr(log_clr), .irq_en(irq_en), .irq(d2_irq)
  );

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model
  typedef struct packed {
    logic [15:0] d;
    logic [7:0]  t;
    logic        p;
  } ent_t;

  ent_t q[$];
  int   m_sec, m_ded, m_sec2, m_ded2;
  bit   m_lv, m_ov, m_ld, m_irq, armed;
  logic [7:0] m_tag;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_sec = 0; m_ded = 0; m_sec2 = 0; m_ded2 = 0;
      m_lv = 0; m_ov = 0; m_ld = 0; m_irq = 0;
      m_tag = 0;
      armed = 1;
    end else begin
      bit push, pop, err;
      push = in_valid && (q.size() < DEPTH);
      pop  = out_ready && (q.size() > 0);
      err  = push && (in_sec || in_ded);
      m_irq = m_lv && m_ld && irq_en;
      if (pop) void'(q.pop_front());
      if (push) q.push_back({in_data, in_tag, in_ded});
      if (push && in_ded) begin
        if (m_ded < MAX1) m_ded++;
        if (m_ded2 < MAX2) m_ded2++;
      end else if (push && in_sec) begin
        if (m_sec < MAX1) m_sec++;
        if (m_sec2 < MAX2) m_sec2++;
      end
      if (log_clr) begin
        m_lv = 0; m_ov = 0;
      end
      if (err) begin
        if (!m_lv) begin
          m_lv = 1; m_tag = in_tag; m_ld = in_ded;
        end else begin
          m_ov = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("in_ready", in_ready, q.size() < DEPTH);
      chk("out_valid", out_valid, q.size() > 0);
      if (q.size() > 0) begin
        chk("out_data", out_data, q[0].d);
        chk("out_tag", out_tag, q[0].t);
        chk("out_poison", out_poison, q[0].p);
      end
      chk("sec_count", sec_count, m_sec);
      chk("ded_count", ded_count, m_ded);
      chk("sec_count2", d2_sec, m_sec2);
      chk("ded_count2", d2_ded, m_ded2);
      chk("log_valid", log_valid, m_lv);
      chk("log_overrun", log_overrun, m_ov);
      if (m_lv) begin
        chk("log_tag", log_tag, m_tag);
        chk("log_ded", log_ded, m_ld);
      end
      chk("irq", irq, m_irq);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick();
    tick();
    // reset state
    chk("rst in_ready", in_ready, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_data", out_data, 0);
    chk("rst out_tag", out_tag, 0);
    chk("rst out_poison", out_poison, 0);
    chk("rst log_tag", log_tag, 0);
    chk("rst log_ded", log_ded, 0);
    chk("rst irq", irq, 0);
    rst = 0;

    // fill with clean words, then drain
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1; in_data = 16'(i); in_tag = 8'(i);
      tick();
      if (i == 3) chk("fill ready3", in_ready, 1);
    end
    chk("full ready", in_ready, 0);
    in_valid = 0; out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain data", out_data, i);
      tick();
    end
    chk("drained", out_valid, 0);
    chk("clean sec", sec_count, 0);

    // SEC then DED
    out_ready = 0; in_valid = 1;
    in_data = 16'hBEEF; in_tag = 8'h12; in_sec = 1;
    tick();
    in_data = 16'hCAFE; in_tag = 8'h34;
    in_sec = 0; in_ded = 1;
    tick();
    in_valid = 0; in_ded = 0;
    chk("s2 sec", sec_count, 1);
    chk("s2 ded", ded_count, 1);
    chk("s2 lv", log_valid, 1);
    chk("s2 ld", log_ded, 0);
    chk("s2 tag", log_tag, 8'h12);
    chk("s2 ovr", log_overrun, 1);
    chk("s2 head", out_data, 16'hBEEF);
    out_ready = 1;
    tick();
    chk("s2 poison", out_poison, 1);
    tick();
    chk("s2 irq", irq, 0);

    // clear, then DED with irq enabled
    log_clr = 1;
    tick();
    log_clr = 0; irq_en = 1;
    in_valid = 1; in_data = 16'h1234;
    in_tag = 8'h55; in_ded = 1;
    tick();
    in_valid = 0; in_ded = 0;
    chk("s3 lv", log_valid, 1);
    chk("s3 tag", log_tag, 8'h55);
    chk("s3 ld", log_ded, 1);
    chk("s3 irq0", irq, 0);
    tick();
    chk("s3 irq1", irq, 1);

    // clear coincident with SEC push
    log_clr = 1; in_valid = 1; in_sec = 1;
    in_tag = 8'h77;
    tick();
    log_clr = 0; in_valid = 0; in_sec = 0;
    chk("s4 lv", log_valid, 1);
    chk("s4 tag", log_tag, 8'h77);
    chk("s4 ovr", log_overrun, 0);
    chk("s4 ld", log_ded, 0);

    // saturation on the narrow-counter instance
    irq_en = 0; rst = 1;
    tick();
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_sec = 1; in_ded = 1;
      in_tag = 8'(i);
      tick();
    end
    in_valid = 0; in_sec = 0; in_ded = 0;
    chk("sat ded2", d2_ded, 3);
    chk("sat sec2", d2_sec, 0);
    chk("sat ded", ded_count, 5);
    tick();

    // reset while busy
    out_ready = 0; log_clr = 1;
    tick();
    log_clr = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_sec = (i == 0);
      in_tag = 8'(8'h40 + i);
      tick();
    end
    in_valid = 0; in_sec = 0;
    chk("s6 lv pre", log_valid, 1);
    rst = 1;
    tick();
    rst = 0;
    chk("s6 ov", out_valid, 0);
    chk("s6 ir", in_ready, 1);
    chk("s6 sec", sec_count, 0);
    chk("s6 lv", log_valid, 0);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom % 400) == 0;
      in_valid  = ($urandom % 4) != 0;
      in_data   = 16'($urandom);
      in_tag    = 8'($urandom);
      in_sec    = ($urandom % 4) == 0;
      in_ded    = ($urandom % 6) == 0;
      out_ready = (c % 200 < 100) ?
                  (($urandom % 3) != 0) :
                  (($urandom % 3) == 0);
      log_clr   = ($urandom % 16) == 0;
      irq_en    = ($urandom % 8) != 0;
      tick();
    end
    rst = 0; in_valid = 0; log_clr = 0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ecc_result_collector.md
# ecc_result_collector

Downstream stage of the 16-bit SEC/DED checker/corrector. Accepts each corrected data word with its single-error (corrected) and double-error (uncorrectable) flags through a valid/ready handshake, and buffers the words in a small FIFO for the consumer. It keeps saturating error counters and a sticky first-error log with an interrupt. This turns the purely combinational checker into a flow-controlled, observable pipeline stage.

## Interface

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- TAG_W, 8, width of the word tag (address or sequence number) carried alongside each word.
- CNT_W, 16, width of each error counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  block can accept a word.
- in_data  in  16  corrected data word from the checker.
- in_tag  in  TAG_W  tag of the word.
- in_sec  in  1  single error detected and corrected.
- in_ded  in  1  double error detected, not correctable.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts the head.
- out_data  out  16  head data.
- out_tag  out  TAG_W  head tag.
- out_poison  out  1  head word carried in_ded.
- sec_count  out  CNT_W  accepted single-error words, saturating.
- ded_count  out  CNT_W  accepted double-error words, saturating.
- log_valid  out  1  log holds a captured error.
- log_ded  out  1  captured error was a DED (0 means SEC).
- log_tag  out  TAG_W  tag of the first captured error.
- log_overrun  out  1  at least one further error arrived while the log was held.
- log_clr  in  1  one-cycle pulse that clears the log.
- irq_en  in  1  interrupt enable.
- irq  out  1  registered interrupt: log_valid & log_ded & irq_en.

## Operation

- Push: in_valid & in_ready. Pop: out_valid & out_ready.
- The FIFO stores {data, tag, poison}, where poison = in_ded.
- in_ready = !full. out_valid = !empty.
- No bypass path. A word pushed into an empty FIFO appears at the output the next cycle.
- Push and pop in the same cycle: occupancy is unchanged. This is allowed whenever the FIFO is neither full nor empty.
- Full: in_ready stays low, so no push can occur and a pop cannot make room in the same cycle.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. The occupancy counter is log2(DEPTH)+1 bits.
- Error class of an accepted word:
  - in_ded=1: DED, regardless of in_sec.
  - in_sec=1, in_ded=0: SEC.
  - Otherwise: clean.
  - Flags on cycles without a push are ignored.
- Counters: on a push, ded_count or sec_count increments by 1 according to the class. Each counter holds at 2^CNT_W-1.
- Log FSM states:
  - IDLE, HELD, OVERRUN.
  - IDLE, push with error: go to HELD; capture the tag and log_ded.
  - HELD, push with error: go to OVERRUN; captured fields are unchanged.
  - OVERRUN absorbs further errors.
  - log_clr in any state: go to IDLE.
  - log_clr in the same cycle as a push with error: go to HELD and capture the new word. The clear takes priority, then the capture.
- Outputs from FSM state: log_valid = (state != IDLE); log_overrun = (state == OVERRUN).

## Timing

- Everything is registered except in_ready, out_valid and the FIFO head read, which are decoded from state.
- Latency, push to out_valid: 1 cycle.
- Latency, push to counter/log update: 1 cycle.
- Latency, log update to irq: 1 additional cycle.
- Reset values:
  - FIFO empty, so in_ready=1 and out_valid=0.
  - out_data, out_tag and out_poison all 0; storage is cleared.
  - Both counters 0.
  - FSM in IDLE; log_tag=0, log_ded=0, irq=0.
- Reset mid-operation discards buffered words and any in-flight handshake. in_ready returns to 1 on the cycle after rst deasserts.
- Throughput: one word per cycle while out_ready is held high.

## Structure

- Package ecc_collect_pkg contains:
  - log_state_t enum {LOG_IDLE, LOG_HELD, LOG_OVERRUN};
  - err_class_t enum {ERR_NONE, ERR_SEC, ERR_DED};
  - the default DEPTH, TAG_W and CNT_W.
- Sub-module ecc_sync_fifo: parameterised width and depth, with valid/ready on both sides.
- The top level holds the counters, the log FSM and irq.

## Test plan

- Reset, then push 4 clean words 0x0001..0x0004 with out_ready=0: in_ready drops after the 4th push. Raise out_ready: words come out in order, counters stay 0.
- Push 0xBEEF with tag 0x12 and in_sec=1, then 0xCAFE with tag 0x34 and in_ded=1: sec_count=1, ded_count=1. log_valid=1, log_ded=0, log_tag=0x12, log_overrun=1. The second word shows out_poison=1. irq stays 0.
- log_clr pulse, then a DED word with tag 0x55 and irq_en=1: log_tag=0x55, log_ded=1. irq rises 1 cycle after log_valid.
- log_clr in the same cycle as a SEC push with tag 0x77: next cycle the FSM is HELD with log_tag=0x77 and log_overrun=0.
- With CNT_W=2, push 5 words with in_sec=1 and in_ded=1 together: ded_count saturates at 3, sec_count stays 0.
- Assert rst with 3 words buffered and the log HELD: the next cycle shows out_valid=0, in_ready=1, counters 0, log_valid=0.
